// File: rtl/watchdog_kicker.sv
// Periodically borrows the 68k bus and writes the watchdog kick address.
// Define WDKICK_DTACK_TIMEOUT_EN to abandon a strobe that gets no nDTACK within 255 CLK.
`timescale 1ns/1ps
module watchdog_kicker #(
  parameter int unsigned INTERVAL      = 4,
  parameter int unsigned STROBE_CYCLES = 3,
  parameter logic [22:0] KICK_ADDR     = 23'h180000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        EN,
  input  logic        WDCLK,
  input  logic        BUS_GNT,
  input  logic        nDTACK,
  output logic        BUS_REQ,
  output logic [22:0] M68K_ADDR,
  output logic        nAS,
  output logic        nLDS,
  output logic        nUDS,
  output logic        RW,
  output logic        BUSY,
  output logic        MISSED,
  output logic [7:0]  KICK_CNT
);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, STROBE, RELEASE} state_e;

  localparam logic [2:0] EDGE_LAST = 3'(INTERVAL - 1);
  localparam logic [7:0] STRB_LOAD = 8'(STROBE_CYCLES);

  state_e      state_q, state_d;
  logic        wd_s1_q, wd_s2_q, wd_dly_q;
  logic        wd_edge;
  logic [2:0]  edge_cnt_q, edge_cnt_d;
  logic        pending_q, pending_d;
  logic        missed_q, missed_d;
  logic [7:0]  kick_cnt_q, kick_cnt_d;
  logic [7:0]  strb_q, strb_d;
  logic [7:0]  strb_left;
  logic        bus_req_q, bus_req_d;
  logic        nas_q, nas_d;
  logic        nlds_q, nlds_d;
  logic        rw_q, rw_d;
  logic [22:0] addr_q, addr_d;
`ifdef WDKICK_DTACK_TIMEOUT_EN
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  assign wd_edge   = wd_s2_q & ~wd_dly_q;
  assign strb_left = (strb_q == 8'd0) ? 8'd0 : strb_q - 8'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    pending_d  = pending_q;
    missed_d   = missed_q;
    kick_cnt_d = kick_cnt_q;
    strb_d     = strb_q;
    bus_req_d  = bus_req_q;
    nas_d      = nas_q;
    nlds_d     = nlds_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
`ifdef WDKICK_DTACK_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (pending_q && EN) begin
          state_d   = REQ;
          bus_req_d = 1'b1;
        end
      end
      REQ: begin
        if (!EN) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end else if (BUS_GNT) begin
          state_d = ADDR;
          addr_d  = KICK_ADDR;
          rw_d    = 1'b0;
          nas_d   = 1'b0;
        end
      end
      ADDR: begin
        state_d = STROBE;
        nlds_d  = 1'b0;
        strb_d  = STRB_LOAD;
`ifdef WDKICK_DTACK_TIMEOUT_EN
        to_cnt_d = 8'd0;
`endif
      end
      STROBE: begin
        strb_d = strb_left;
`ifdef WDKICK_DTACK_TIMEOUT_EN
        to_cnt_d = to_cnt_q + 8'd1;
`endif
        // An early nDTACK is held off until the minimum strobe width has elapsed.
        if (strb_left == 8'd0 && !nDTACK) begin
          state_d = RELEASE;
          nlds_d  = 1'b1;
          nas_d   = 1'b1;
        end
`ifdef WDKICK_DTACK_TIMEOUT_EN
        else if (to_cnt_q == 8'd254) begin
          state_d   = RELEASE;
          nlds_d    = 1'b1;
          nas_d     = 1'b1;
          timeout_d = 1'b1;
        end
`endif
      end
      RELEASE: begin
        state_d   = IDLE;
        rw_d      = 1'b1;
        bus_req_d = 1'b0;
        addr_d    = 23'd0;
        pending_d = 1'b0;
`ifdef WDKICK_DTACK_TIMEOUT_EN
        timeout_d = 1'b0;
        if (timeout_q) missed_d = 1'b1;
        else           kick_cnt_d = kick_cnt_q + 8'd1;
`else
        kick_cnt_d = kick_cnt_q + 8'd1;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Interval tracking overrides the release-time clear of pending.
    if (!EN) begin
      edge_cnt_d = 3'd0;
      pending_d  = 1'b0;
    end else if (wd_edge) begin
      if (edge_cnt_q == EDGE_LAST) begin
        edge_cnt_d = 3'd0;
        if (pending_q && state_q != RELEASE) missed_d = 1'b1;
        pending_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!nRST) begin
      state_q    <= IDLE;
      wd_s1_q    <= 1'b0;
      wd_s2_q    <= 1'b0;
      wd_dly_q   <= 1'b0;
      edge_cnt_q <= 3'd0;
      pending_q  <= 1'b0;
      missed_q   <= 1'b0;
      kick_cnt_q <= 8'd0;
      strb_q     <= 8'd0;
      bus_req_q  <= 1'b0;
      nas_q      <= 1'b1;
      nlds_q     <= 1'b1;
      rw_q       <= 1'b1;
      addr_q     <= 23'd0;
`ifdef WDKICK_DTACK_TIMEOUT_EN
      to_cnt_q   <= 8'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wd_s1_q    <= WDCLK;
      wd_s2_q    <= wd_s1_q;
      wd_dly_q   <= wd_s2_q;
      edge_cnt_q <= edge_cnt_d;
      pending_q  <= pending_d;
      missed_q   <= missed_d;
      kick_cnt_q <= kick_cnt_d;
      strb_q     <= strb_d;
      bus_req_q  <= bus_req_d;
      nas_q      <= nas_d;
      nlds_q     <= nlds_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
`ifdef WDKICK_DTACK_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign BUS_REQ   = bus_req_q;
  assign M68K_ADDR = addr_q;
  assign nAS       = nas_q;
  assign nLDS      = nlds_q;
  assign nUDS      = 1'b1;
  assign RW        = rw_q;
  assign BUSY      = (state_q != IDLE);
  assign MISSED    = missed_q;
  assign KICK_CNT  = kick_cnt_q;

endmodule

// File: tb/tb_watchdog_kicker.sv
// Scoreboard bench for watchdog_kicker: expected kicks are queued when stimulus is
// applied and compared by a bus-cycle monitor when the DUT completes each cycle.
`timescale 1ns/1ps
module tb_watchdog_kicker;

  localparam logic [22:0] KICK_ADDR = 23'h180000;

  logic        CLK = 1'b0;
  logic        nRST, EN, WDCLK, BUS_GNT, nDTACK;
  logic        BUS_REQ, nAS, nLDS, nUDS, RW, BUSY, MISSED;
  logic [22:0] M68K_ADDR;
  logic [7:0]  KICK_CNT;

  typedef struct {
    logic [22:0] addr;
    int          lds_min;
    int          lds_max;
  } kick_t;

  kick_t       exp_q[$];
  kick_t       exp_e;
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [7:0]  exp_kicks = 8'd0;

  always #5 CLK = ~CLK;

  watchdog_kicker dut (
    .CLK(CLK), .nRST(nRST), .EN(EN), .WDCLK(WDCLK), .BUS_GNT(BUS_GNT), .nDTACK(nDTACK),
    .BUS_REQ(BUS_REQ), .M68K_ADDR(M68K_ADDR), .nAS(nAS), .nLDS(nLDS), .nUDS(nUDS),
    .RW(RW), .BUSY(BUSY), .MISSED(MISSED), .KICK_CNT(KICK_CNT)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus-cycle monitor: samples on the falling edge, pops one expectation per completed cycle.
  logic        in_cyc = 1'b0;
  logic [22:0] cyc_addr;
  logic        cyc_rw, cyc_uds;
  int          lds_len;

  always @(negedge CLK) begin
    if (!nRST) begin
      in_cyc = 1'b0;
    end else begin
      if (!in_cyc && !nAS) begin
        in_cyc   = 1'b1;
        cyc_addr = M68K_ADDR;
        cyc_rw   = RW;
        cyc_uds  = nUDS;
        lds_len  = 0;
      end
      if (in_cyc && !nLDS) lds_len++;
      if (in_cyc && nAS) begin
        in_cyc = 1'b0;
        check("kick_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("kick_addr", 32'(cyc_addr), 32'(exp_e.addr));
          check("kick_rw", 32'(cyc_rw), 0);
          check("kick_nuds", 32'(cyc_uds), 1);
          if (exp_e.lds_min == exp_e.lds_max)
            check("nlds_low_cycles", lds_len, exp_e.lds_min);
          else
            check("nlds_low_in_range", 32'(lds_len >= exp_e.lds_min && lds_len <= exp_e.lds_max), 1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wd_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      WDCLK = 1'b1; tick(4);
      WDCLK = 1'b0; tick(4);
    end
  endtask

  task automatic expect_kick(input int mn, input int mx, input bit counted);
    exp_q.push_back('{addr: KICK_ADDR, lds_min: mn, lds_max: mx});
    if (counted) exp_kicks = exp_kicks + 8'd1;
  endtask

  task automatic wait_kick_cnt(input int budget);
    int i = 0;
    while (KICK_CNT !== exp_kicks && i < budget) begin tick(1); i++; end
    check("kick_cnt", 32'(KICK_CNT), 32'(exp_kicks));
  endtask

  task automatic wait_lds_low(input int budget);
    int i = 0;
    while (nLDS !== 1'b0 && i < budget) begin tick(1); i++; end
    check("nlds_fell", 32'(nLDS), 0);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (BUSY !== 1'b0 && i < budget) begin tick(1); i++; end
    check("busy_idle", 32'(BUSY), 0);
  endtask

  task automatic apply_reset();
    nRST = 1'b0; WDCLK = 1'b0;
    tick(2);
    nRST = 1'b1;
    exp_kicks = 8'd0;
    exp_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL sim_timeout: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; EN = 1'b0; WDCLK = 1'b0; BUS_GNT = 1'b0; nDTACK = 1'b1;
    tick(3);
    nRST = 1'b1;
    tick(1);
    check("rst_bus_req", 32'(BUS_REQ), 0);
    check("rst_nas", 32'(nAS), 1);
    check("rst_nlds", 32'(nLDS), 1);
    check("rst_nuds", 32'(nUDS), 1);
    check("rst_rw", 32'(RW), 1);
    check("rst_addr", 32'(M68K_ADDR), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_missed", 32'(MISSED), 0);
    check("rst_kick_cnt", 32'(KICK_CNT), 0);

    // Basic kick: nothing after 3 edges, one cycle after the 4th.
    EN = 1'b1; BUS_GNT = 1'b1; nDTACK = 1'b0;
    wd_pulses(3);
    tick(10);
    check("no_kick_3_edges", 32'(KICK_CNT), 0);
    check("idle_3_edges", 32'(BUSY), 0);
    expect_kick(3, 3, 1'b1);
    wd_pulses(1);
    wait_kick_cnt(50);
    check("rel_bus_req", 32'(BUS_REQ), 0);
    check("rel_rw", 32'(RW), 1);
    wait_idle(10);

    // Grant withheld across two intervals: request held, MISSED at the second.
    BUS_GNT = 1'b0;
    wd_pulses(4);
    check("req_held", 32'(BUS_REQ), 1);
    check("missed_first", 32'(MISSED), 0);
    wd_pulses(4);
    check("missed_second", 32'(MISSED), 1);
    check("req_still_held", 32'(BUS_REQ), 1);
    expect_kick(3, 3, 1'b1);
    BUS_GNT = 1'b1;
    wait_kick_cnt(30);
    tick(30);
    check("single_kick", 32'(KICK_CNT), 32'(exp_kicks));
    check("idle_after_single", 32'(BUSY), 0);

    // Reset in the middle of a strobe.
    nDTACK = 1'b1;
    wd_pulses(3);
    WDCLK = 1'b1;
    wait_lds_low(20);
    tick(1);
    nRST = 1'b0; WDCLK = 1'b0;
    tick(1);
    nRST = 1'b1;
    exp_kicks = 8'd0;
    check("mid_rst_nas", 32'(nAS), 1);
    check("mid_rst_nlds", 32'(nLDS), 1);
    check("mid_rst_rw", 32'(RW), 1);
    check("mid_rst_bus_req", 32'(BUS_REQ), 0);
    check("mid_rst_kick_cnt", 32'(KICK_CNT), 0);
    check("mid_rst_busy", 32'(BUSY), 0);
    check("mid_rst_missed", 32'(MISSED), 0);

    // nDTACK arrives 10 cycles after nLDS falls.
    expect_kick(10, 11, 1'b1);
    wd_pulses(3);
    WDCLK = 1'b1;
    wait_lds_low(20);
    tick(10);
    check("nlds_held_no_dtack", 32'(nLDS), 0);
    nDTACK = 1'b0; WDCLK = 1'b0;
    wait_kick_cnt(20);
    tick(4);

    // nDTACK low at strobe count 1: full minimum strobe still applies.
    nDTACK = 1'b1;
    expect_kick(3, 3, 1'b1);
    wd_pulses(3);
    WDCLK = 1'b1;
    wait_lds_low(20);
    tick(2);
    nDTACK = 1'b0; WDCLK = 1'b0;
    wait_kick_cnt(20);
    tick(4);

    // EN dropped while requesting.
    BUS_GNT = 1'b0;
    wd_pulses(4);
    check("en_req_up", 32'(BUS_REQ), 1);
    EN = 1'b0;
    tick(1);
    check("en_req_drop", 32'(BUS_REQ), 0);
    check("en_busy_drop", 32'(BUSY), 0);
    tick(5);
    check("en_kick_cnt", 32'(KICK_CNT), 32'(exp_kicks));
    EN = 1'b1; BUS_GNT = 1'b1;
    tick(20);
    check("en_pending_cleared", 32'(BUSY), 0);
    check("en_no_missed", 32'(MISSED), 0);

    // 256 kicks wrap the counter back to 0.
    apply_reset();
    for (int k = 0; k < 256; k++) begin
      expect_kick(3, 3, 1'b1);
      wd_pulses(4);
      wait_kick_cnt(40);
    end
    check("kick_cnt_wrap", 32'(KICK_CNT), 0);
    check("wrap_no_missed", 32'(MISSED), 0);

`ifdef WDKICK_DTACK_TIMEOUT_EN
    nDTACK = 1'b1;
    expect_kick(255, 255, 1'b0);
    wd_pulses(4);
    wait_idle(400);
    check("timeout_missed", 32'(MISSED), 1);
    check("timeout_not_counted", 32'(KICK_CNT), 32'(exp_kicks));
    nDTACK = 1'b0;
`endif

    tick(10);
    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/watchdog_kicker.md
Name: watchdog_kicker

Overview:
- Bus-master-side companion to the NeoGeo watchdog.
- Counts WDCLK (vblank-rate) rising edges. Every INTERVAL edges it requests the 68k bus and runs one byte write cycle (LDS, RW=0) to the watchdog kick address $300001.
- Used by the core's BIOS-skip / debug-halt modes, so the watchdog does not reset the system while the CPU is held off.

Parameters:
- INTERVAL, 4: WDCLK rising edges between kicks; legal 1..7, below the watchdog's 8-edge trip.
- STROBE_CYCLES, 3: minimum CLK cycles nLDS is held low.
- KICK_ADDR, 23'h180000: word address A23..A1 driven during the kick ($300001 >> 1).

Ports:
- CLK  in  1  system clock
- nRST  in  1  synchronous active-low reset
- EN  in  1  kicking enabled; 0 = counter cleared, no new requests
- WDCLK  in  1  watchdog time base, asynchronous to CLK
- BUS_GNT  in  1  bus grant from arbiter; high = this block owns the bus
- nDTACK  in  1  data acknowledge from the bus decoder, active low
- BUS_REQ  out  1  bus request to arbiter
- M68K_ADDR  out  23  A23..A1, valid while nAS low
- nAS  out  1  address strobe
- nLDS  out  1  lower data strobe
- nUDS  out  1  upper data strobe; always 1 (byte write)
- RW  out  1  0 = write during the cycle, else 1
- BUSY  out  1  high in any state other than IDLE
- MISSED  out  1  sticky: an interval elapsed while a kick was still pending
- KICK_CNT  out  8  completed kicks, wraps 255 -> 0

Behaviour:
- Reset is synchronous on posedge CLK with nRST=0. It takes priority over everything, including mid-cycle.
- Reset values: BUS_REQ=0, nAS=1, nLDS=1, nUDS=1, RW=1, M68K_ADDR=0, BUSY=0, MISSED=0, KICK_CNT=0, edge counter=0, pending=0, state=IDLE.
- WDCLK handling:
  - 2-flop synchronizer, then a delay flop.
  - A rising edge is detected when the synced value is 1 and the delayed value is 0: one CLK pulse, 3 CLK after the WDCLK transition.
- Edge counter: 3 bits.
  - Increments on each detected edge while EN=1.
  - When it equals INTERVAL-1 and an edge arrives, it clears to 0 and sets pending.
  - If pending is already 1 at that moment, MISSED is set instead; pending stays 1.
  - EN=0 clears the counter and pending. It does not abort a cycle already past REQ.
- FSM (one transition per CLK):
  - IDLE: pending=1 -> REQ, BUS_REQ=1.
  - REQ: hold BUS_REQ=1.
    - BUS_GNT=1 -> ADDR: drive M68K_ADDR=KICK_ADDR, RW=0, nAS=0.
    - EN falls while in REQ -> IDLE: drop BUS_REQ, clear pending.
  - ADDR: 1 cycle, then nLDS=0 -> STROBE, strobe counter loaded with STROBE_CYCLES.
  - STROBE: counter decrements each cycle.
    - Leave when counter=0 and nDTACK=0 -> RELEASE.
    - nDTACK sampled low earlier only ends the cycle once the counter reaches 0.
  - RELEASE: nLDS=1 and nAS=1 this cycle, RW=1 and BUS_REQ=0 the next cycle, KICK_CNT+1, pending cleared -> IDLE.
    - An edge that sets pending in the same cycle takes precedence over the clear: pending stays 1 and MISSED is not set.
- Minimum kick length: 1 (REQ with grant) + 1 (ADDR) + STROBE_CYCLES + 1 (RELEASE) cycles.
- Losing BUS_GNT in ADDR or STROBE is ignored: the cycle completes (bus cycles are never torn).
- nUDS is held at 1 at all times.

Optional Feature:
- Macro: WDKICK_DTACK_TIMEOUT_EN
- With the macro: an 8-bit counter runs in STROBE.
  - If nDTACK has not gone low within 255 CLK of entering STROBE, go to RELEASE anyway.
  - The kick is not counted in KICK_CNT, and MISSED is set.
- Without the macro: STROBE waits for nDTACK indefinitely; only reset aborts.

Test Plan:
- Reset mid-STROBE (nRST=0 one cycle) -> next cycle nAS=nLDS=RW=1, BUS_REQ=0, KICK_CNT=0, BUSY=0.
- EN=1, INTERVAL=4, BUS_GNT tied 1, nDTACK tied 0; 4 WDCLK pulses -> exactly one cycle:
  - M68K_ADDR=23'h180000, RW=0, nUDS=1
  - nLDS low exactly 3 cycles
  - KICK_CNT=1
  - no kick after 3 pulses
- BUS_GNT held 0 for 8 WDCLK pulses -> BUS_REQ stays 1, MISSED=1 at the second interval. Grant then given -> one kick only, KICK_CNT=1.
- nDTACK delayed 10 cycles after nLDS falls -> nLDS low 10 or 11 cycles, no early release. Then nDTACK low at strobe count 1 -> nLDS still low the full 3 cycles.
- EN dropped while in REQ -> BUS_REQ falls next cycle, no bus cycle issued, KICK_CNT unchanged. 256 completed kicks -> KICK_CNT=0.
- (With WDKICK_DTACK_TIMEOUT_EN) nDTACK tied 1 -> strobe released after 255 cycles, MISSED=1, KICK_CNT unchanged.
